// File: rtl/bcd_7seg_scan.sv
// bcd_7seg_scan: two-digit multiplexed seven-segment driver.
// Holds a captured BCD pair (tens, ones) and alternates a single segment bus
// between two digit enables. Supports optional leading-zero blanking of the
// tens digit, and shows a dash for any non-BCD nibble.
module bcd_7seg_scan #(
   parameter int unsigned REFRESH_DIV = 1000,
   parameter int unsigned ACTIVE_LOW  = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   input  logic       blank_lz,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       err
);

   localparam int unsigned    CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(REFRESH_DIV - 1);

   typedef enum logic {
      SEL_ONES = 1'b0,
      SEL_TENS = 1'b1
   } sel_t;

   logic [3:0]    tens_q;
   logic [3:0]    ones_q;
   logic          blz_q;
   logic [CW-1:0] cnt;
   sel_t          sel;

   logic [3:0]    digit;
   logic [6:0]    dec;
   logic          blank;
   logic [6:0]    seg_n;
   logic [1:0]    an_n;
   logic          err_n;

   logic [6:0]    seg_r;
   logic [1:0]    an_r;
   logic          err_r;

   // Capture the displayed value whenever load is high; held until next load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tens_q <= '0;
         ones_q <= '0;
         blz_q  <= 1'b0;
      end else if (load) begin
         tens_q <= tens;
         ones_q <= ones;
         blz_q  <= blank_lz;
      end
   end

   // Refresh counter and digit-select state; select flips on counter wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         sel <= SEL_ONES;
      end else if (cnt == CNT_MAX) begin
         cnt <= '0;
         sel <= (sel == SEL_ONES) ? SEL_TENS : SEL_ONES;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Decode the selected digit and apply leading-zero blanking.
   always_comb begin
      digit = (sel == SEL_TENS) ? tens_q : ones_q;
      case (digit)
         4'd0:    dec = 7'b0111111;
         4'd1:    dec = 7'b0000110;
         4'd2:    dec = 7'b1011011;
         4'd3:    dec = 7'b1001111;
         4'd4:    dec = 7'b1100110;
         4'd5:    dec = 7'b1101101;
         4'd6:    dec = 7'b1111101;
         4'd7:    dec = 7'b0000111;
         4'd8:    dec = 7'b1111111;
         4'd9:    dec = 7'b1101111;
         default: dec = 7'b1000000;
      endcase
      blank = blz_q && (tens_q == 4'd0) && (sel == SEL_TENS);
      seg_n = blank ? '0 : dec;
      an_n  = blank ? '0 : ((sel == SEL_TENS) ? 2'b10 : 2'b01);
      err_n = (tens_q > 4'd9) || (ones_q > 4'd9);
   end

   // Output register: one cycle from held/select state to the pins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_r <= '0;
         an_r  <= '0;
         err_r <= 1'b0;
      end else begin
         seg_r <= seg_n;
         an_r  <= an_n;
         err_r <= err_n;
      end
   end

   assign seg = (ACTIVE_LOW != 0) ? ~seg_r : seg_r;
   assign an  = (ACTIVE_LOW != 0) ? ~an_r  : an_r;
   assign err = err_r;

endmodule

// File: doc/bcd_7seg_scan.md
Name: bcd_7seg_scan

Overview:
- Downstream display stage for the binary-to-BCD converter.
- Captures a two-digit BCD value (tens, ones) on a load strobe.
- Drives a two-digit multiplexed seven-segment display: time-shares one segment bus between two digit enables using a refresh counter.
- Provides optional leading-zero blanking and flags any non-BCD nibble by showing a dash.

Parameters:
- REFRESH_DIV, 1000: clock cycles each digit stays enabled before the scan advances; legal range 2..65535.
- ACTIVE_LOW, 0: 1 inverts the seg and an outputs for common-anode hardware; 0 means active-high.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- load  input  1  capture strobe; samples tens, ones and blank_lz when high at a rising clk edge
- tens  input  4  BCD tens digit
- ones  input  4  BCD ones digit
- blank_lz  input  1  1 = blank the tens digit when the held tens value is 0
- seg  output  7  segments {g,f,e,d,c,b,a}, registered
- an  output  2  digit enables, an[1]=tens, an[0]=ones, registered
- err  output  1  high while either held digit is greater than 9, registered

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - Held tens, ones and blank_lz registers clear to 0.
  - Refresh counter clears to 0; digit select clears to 0 (ones).
  - Raw seg = 0000000, raw an = 00, err = 0.
  - With ACTIVE_LOW=1 the pins read seg=1111111, an=11.
- Capture:
  - load high at an edge writes the held registers at that edge.
  - No handshake back-pressure; load is accepted every cycle.
  - Held values persist until the next load or reset.
- Refresh counter:
  - Width is ceil(log2(REFRESH_DIV)) bits.
  - Increments every cycle.
  - At REFRESH_DIV-1 it wraps to 0 and the digit select toggles in the same cycle.
  - The counter and digit select are unaffected by load.
- Output register, every edge:
  - an = 01 when select=0, 10 when select=1.
  - seg = decode of the selected held digit.
  - Latency is 1 cycle from the held or select register to the pins.
  - A load at edge N appears on seg at edge N+1 if that digit is currently selected.
- Decode (raw, active-high):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - 10..15 = 1000000 (dash)
- Leading-zero blanking:
  - Applies when the held blank_lz=1, the held tens=0 and select=1.
  - Then seg=0000000 and an=00 (tens digit fully dark).
  - The ones digit always displays, including 0.
- err:
  - Registered (held tens>9) OR (held ones>9).
  - Updates 1 cycle after load, independent of scan position.
- ACTIVE_LOW=1: seg and an are bitwise inverted after the output register; err is never inverted.
- Simultaneous load and scan wrap in the same cycle: both take effect. The next output cycle shows the new value of the newly selected digit.
- Reset asserted mid-scan: all state returns to reset values at once. After release, the first edge shows the ones digit (0) with counter=1.
- Digit enables are never both active in the same cycle.

Test Plan:
1. Reset and first scan: ACTIVE_LOW=0, REFRESH_DIV=4, rst_n low then released, no load -> seg=0000000, an=00 during reset; first edge gives an=01, seg=0111111; an switches to 10 after the 4th edge, seg=0111111 for tens 0 with blank_lz=0.
2. Load 4,7: load tens=4, ones=7, blank_lz=0 for one cycle -> within 2 cycles seg=0000111 while an=01 and seg=1100110 while an=10; pattern alternates every 4 cycles; err=0.
3. Leading-zero blank: load tens=0, ones=5, blank_lz=1 -> an=01, seg=1101101 during the ones phase; an=00, seg=0000000 during the tens phase. Reload with blank_lz=0 -> tens shows 0111111.
4. Invalid BCD: load tens=12, ones=3 -> err=1 one cycle after load; tens phase seg=1000000; ones phase seg=1001111. Load 9,9 -> err=0 next cycle, both digits 1101111.
5. Load coincident with wrap: load 8,1 on the cycle the counter is at 3 -> next edge an=10, seg=1111111; err stays 0.
6. ACTIVE_LOW=1 plus async reset mid-scan: load 2,6 then pull rst_n low between edges -> seg=1111111 and an=11 immediately, without waiting for a clock edge. After release, the first edge gives an=10 (pins), seg=1000000, ones digit 0 inverted.
